// File: rtl/datapath_checker.sv
// Two-stage checker: recomputes the expected result of a small ALU op and tallies pass/fail/skip.
// Optional macro CHECKER_STOP_ON_FAIL_EN halts acceptance after the first mismatch.
module datapath_checker #(
   parameter int DATAWIDTH = 2,
   parameter int CNTWIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 chk_valid,
   output logic                 chk_ready,
   input  logic [3:0]           chk_op,
   input  logic [DATAWIDTH-1:0] chk_a,
   input  logic [DATAWIDTH-1:0] chk_b,
   input  logic                 chk_sel,
   input  logic [DATAWIDTH-1:0] chk_obs,
   output logic [CNTWIDTH-1:0]  pass_cnt,
   output logic [CNTWIDTH-1:0]  fail_cnt,
   output logic [CNTWIDTH-1:0]  skip_cnt,
   output logic                 err,
   output logic [3:0]           err_op,
   output logic [DATAWIDTH-1:0] err_exp
);

   // Shift amount width; a 1-bit datapath still uses one bit of b.
   localparam int SHW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
   localparam logic [DATAWIDTH-1:0] ONE  = DATAWIDTH'(1);
   localparam logic [CNTWIDTH-1:0]  CMAX = '1;

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                          OP_MOD = 4'd4, OP_INC = 4'd5, OP_DEC = 4'd6, OP_SHL = 4'd7,
                          OP_SHR = 4'd8, OP_MUX = 4'd9;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   state_t                r_state;
   logic                  r_ready;
   logic [1:0]            r_vld;      // [0] stage 1 occupied, [1] stage 2 occupied
   logic [3:0]            r_s1_op;
   logic [DATAWIDTH-1:0]  r_s1_a, r_s1_b, r_s1_obs;
   logic                  r_s1_sel;
   logic [3:0]            r_s2_op;
   logic [DATAWIDTH-1:0]  r_s2_exp, r_s2_obs;
   logic                  r_s2_skip;
   logic [CNTWIDTH-1:0]   r_pass, r_fail, r_skip;
   logic                  r_err;
   logic [3:0]            r_err_op;
   logic [DATAWIDTH-1:0]  r_err_exp;

   logic                  w_acc;
   logic [DATAWIDTH-1:0]  w_exp;
   logic                  w_skip;
   logic                  w_fail;

   assign w_acc     = chk_valid & r_ready;
   assign w_fail    = r_vld[1] & ~r_s2_skip & (r_s2_exp != r_s2_obs);
   assign chk_ready = r_ready;
   assign pass_cnt  = r_pass;
   assign fail_cnt  = r_fail;
   assign skip_cnt  = r_skip;
   assign err       = r_err;
   assign err_op    = r_err_op;
   assign err_exp   = r_err_exp;

   always_comb begin
      w_exp  = '0;
      w_skip = 1'b0;
      case (r_s1_op)
         OP_ADD: w_exp = r_s1_a + r_s1_b;
         OP_SUB: w_exp = r_s1_a - r_s1_b;
         OP_MUL: w_exp = r_s1_a * r_s1_b;
         OP_DIV: if (r_s1_b == '0) w_skip = 1'b1; else w_exp = r_s1_a / r_s1_b;
         OP_MOD: if (r_s1_b == '0) w_skip = 1'b1; else w_exp = r_s1_a % r_s1_b;
         OP_INC: w_exp = r_s1_a + ONE;
         OP_DEC: w_exp = r_s1_a - ONE;
         OP_SHL: w_exp = r_s1_a << r_s1_b[SHW-1:0];
         OP_SHR: w_exp = r_s1_a >> r_s1_b[SHW-1:0];
         OP_MUX: w_exp = r_s1_sel ? r_s1_a : r_s1_b;
         default: w_skip = 1'b1;
      endcase
   end

   // Pipeline keeps draining in HALT so the trailing transaction is still counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld     <= '0;
         r_s1_op   <= '0;
         r_s1_a    <= '0;
         r_s1_b    <= '0;
         r_s1_sel  <= 1'b0;
         r_s1_obs  <= '0;
         r_s2_op   <= '0;
         r_s2_exp  <= '0;
         r_s2_obs  <= '0;
         r_s2_skip <= 1'b0;
      end else begin
         r_vld <= {r_vld[0], w_acc};
         if (w_acc) begin
            r_s1_op  <= chk_op;
            r_s1_a   <= chk_a;
            r_s1_b   <= chk_b;
            r_s1_sel <= chk_sel;
            r_s1_obs <= chk_obs;
         end
         if (r_vld[0]) begin
            r_s2_op   <= r_s1_op;
            r_s2_exp  <= w_exp;
            r_s2_obs  <= r_s1_obs;
            r_s2_skip <= w_skip;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pass    <= '0;
         r_fail    <= '0;
         r_skip    <= '0;
         r_err     <= 1'b0;
         r_err_op  <= '0;
         r_err_exp <= '0;
      end else if (r_vld[1]) begin
         if (r_s2_skip) begin
            if (r_skip != CMAX) r_skip <= r_skip + 1'b1;
         end else if (!w_fail) begin
            if (r_pass != CMAX) r_pass <= r_pass + 1'b1;
         end else begin
            if (r_fail != CMAX) r_fail <= r_fail + 1'b1;
            r_err <= 1'b1;
            if (!r_err) begin
               r_err_op  <= r_s2_op;
               r_err_exp <= r_s2_exp;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b1;
         case (r_state)
            S_IDLE:  if (w_acc) r_state <= S_RUN;
            S_RUN:   if (!r_vld[0] && !r_vld[1] && !chk_valid) r_state <= S_IDLE;
            default: begin
               r_state <= S_HALT;
               r_ready <= 1'b0;
            end
         endcase
`ifdef CHECKER_STOP_ON_FAIL_EN
         if (w_fail) begin
            r_state <= S_HALT;
            r_ready <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_datapath_checker.sv
// Directed bench for datapath_checker at DATAWIDTH=4; define CHECKER_STOP_ON_FAIL_EN for the halt scenario.
module tb_datapath_checker;

   localparam int DW = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          chk_valid = 1'b0;
   logic          chk_ready;
   logic [3:0]    chk_op = '0;
   logic [DW-1:0] chk_a = '0, chk_b = '0, chk_obs = '0;
   logic          chk_sel = 1'b0;
   logic [CW-1:0] pass_cnt, fail_cnt, skip_cnt;
   logic          err;
   logic [3:0]    err_op;
   logic [DW-1:0] err_exp;

   int n_tests = 0;
   int n_fail  = 0;

   datapath_checker #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
      .clk(clk), .rst(rst), .chk_valid(chk_valid), .chk_ready(chk_ready),
      .chk_op(chk_op), .chk_a(chk_a), .chk_b(chk_b), .chk_sel(chk_sel), .chk_obs(chk_obs),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
      .err(err), .err_op(err_op), .err_exp(err_exp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic sel, input logic [DW-1:0] obs);
      chk_valid = 1'b1;
      chk_op = op; chk_a = a; chk_b = b; chk_sel = sel; chk_obs = obs;
   endtask

   task automatic idle();
      chk_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_ready", chk_ready, 0);
      chk("rst_pass", pass_cnt, 0);
      chk("rst_fail", fail_cnt, 0);
      chk("rst_skip", skip_cnt, 0);
      chk("rst_err", err, 0);
      chk("rst_err_op", err_op, 0);
      chk("rst_err_exp", err_exp, 0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", chk_ready, 1);
   endtask

   initial begin
      do_reset();
`ifdef CHECKER_STOP_ON_FAIL_EN
      // DEC 4 -> 3 vs obs 2 fails; INC 5 -> 6 passes while draining.
      drive(4'd6, 4'd4, 4'd0, 1'b0, 4'd2); tick();
      drive(4'd5, 4'd5, 4'd0, 1'b0, 4'd6); tick();
      idle(); tick();
      chk("halt_fail", fail_cnt, 1);
      chk("halt_ready", chk_ready, 0);
      tick();
      chk("halt_pass", pass_cnt, 1);
      drive(4'd0, 4'd1, 4'd1, 1'b0, 4'd2); tick();
      idle(); tick(); tick(); tick();
      chk("halt_ignored_pass", pass_cnt, 1);
      chk("halt_ready_hold", chk_ready, 0);
      chk("halt_err_op", err_op, 6);
      chk("halt_err_exp", err_exp, 3);
      do_reset();
`else
      // ADD then SHR back-to-back.
      drive(4'd0, 4'd1, 4'd2, 1'b0, 4'd3); tick();
      drive(4'd8, 4'd8, 4'd2, 1'b0, 4'd2); tick();
      idle();
      chk("add_pass_early", pass_cnt, 0);
      tick();
      chk("add_pass", pass_cnt, 1);
      tick();
      chk("shr_pass", pass_cnt, 2);
      chk("shr_err", err, 0);
      // MUL mismatch captured as first error.
      drive(4'd2, 4'd4, 4'd2, 1'b0, 4'd9); tick();
      idle(); tick();
      chk("mul_fail_early", fail_cnt, 0);
      tick();
      chk("mul_fail", fail_cnt, 1);
      chk("mul_err", err, 1);
      chk("mul_err_op", err_op, 2);
      chk("mul_err_exp", err_exp, 8);
      // Second mismatch must not overwrite the capture.
      drive(4'd1, 4'd5, 4'd4, 1'b0, 4'd0); tick();
      idle(); tick(); tick();
      chk("sub_fail", fail_cnt, 2);
      chk("sub_err_op", err_op, 2);
      chk("sub_err_exp", err_exp, 8);
      chk("sub_ready", chk_ready, 1);
      // Skips: divide by zero and illegal opcode.
      drive(4'd3, 4'd6, 4'd0, 1'b0, 4'd0); tick();
      drive(4'd12, 4'd1, 4'd1, 1'b0, 4'd0); tick();
      idle(); tick(); tick();
      chk("skip_cnt", skip_cnt, 2);
      chk("skip_pass", pass_cnt, 2);
      chk("skip_fail", fail_cnt, 2);
      // Remaining ops with wrap cases, back-to-back.
      drive(4'd4, 4'd7, 4'd3, 1'b0, 4'd1);  tick();
      drive(4'd5, 4'd15, 4'd0, 1'b0, 4'd0); tick();
      drive(4'd6, 4'd0, 4'd0, 1'b0, 4'd15); tick();
      drive(4'd7, 4'd3, 4'd5, 1'b0, 4'd6);  tick();
      drive(4'd9, 4'd2, 4'd9, 1'b0, 4'd9);  tick();
      drive(4'd2, 4'd7, 4'd3, 1'b0, 4'd5);  tick();
      drive(4'd1, 4'd2, 4'd5, 1'b0, 4'd13); tick();
      idle(); tick(); tick();
      chk("mix_pass", pass_cnt, 9);
      chk("mix_fail", fail_cnt, 2);
      // Saturation of pass_cnt under a sustained stream.
      for (int i = 0; i < 260; i++) begin
         drive(4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
         tick();
      end
      idle(); tick(); tick();
      chk("pass_sat", pass_cnt, 255);
      // Reset one cycle after acceptance kills the in-flight transaction.
      drive(4'd9, 4'd2, 4'd3, 1'b1, 4'd2); tick();
      idle();
      rst = 1'b1;
      tick();
      chk("inflight_rst_pass", pass_cnt, 0);
      chk("inflight_rst_ready", chk_ready, 0);
      rst = 1'b0;
      tick();
      chk("inflight_ready", chk_ready, 1);
      tick(); tick();
      chk("inflight_pass", pass_cnt, 0);
      chk("inflight_fail", fail_cnt, 0);
      chk("inflight_skip", skip_cnt, 0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/datapath_checker.md
DATAPATH_CHECKER -- requirements
Module: datapath_checker

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 2: width of operands and observed result.
REQ-002 The block SHALL have parameter CNTWIDTH, default 8: width of each result counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port chk_valid, input, 1 bit: a check transaction is presented.
REQ-006 The block SHALL have port chk_ready, output, 1 bit: the checker can accept a transaction.
REQ-007 The block SHALL have port chk_op, input, 4 bits: operation code: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 INC, 6 DEC, 7 SHL, 8 SHR, 9 MUX2x1; 10-15 illegal.
REQ-008 The block SHALL have ports chk_a and chk_b, input, DATAWIDTH each: operands applied to the unit under check.
REQ-009 The block SHALL have port chk_sel, input, 1 bit: MUX2x1 select.
REQ-010 The block SHALL have port chk_obs, input, DATAWIDTH: result observed from the unit under check.
REQ-011 The block SHALL have ports pass_cnt, fail_cnt and skip_cnt, output, CNTWIDTH each: transaction tallies.
REQ-012 The block SHALL have port err, output, 1 bit: sticky flag, set on any mismatch.
REQ-013 The block SHALL have port err_op, output, 4 bits: opcode of the first mismatch.
REQ-014 The block SHALL have port err_exp, output, DATAWIDTH: expected value of the first mismatch.

Function
REQ-015 A transaction SHALL be accepted on a rising edge where chk_valid and chk_ready are both 1; chk_valid with chk_ready=0 SHALL be ignored, with no stall memory.
REQ-016 Stage 1 SHALL register op, a, b, sel and obs on acceptance and compute the expected value modulo 2^DATAWIDTH:
  - ADD: a+b
  - SUB: a-b
  - MUL: low DATAWIDTH bits of a*b
  - DIV: a/b
  - MOD: a%b
  - INC: a+1
  - DEC: a-1
  - SHL: a<<b[$clog2(DATAWIDTH)-1:0]
  - SHR: a>>b[$clog2(DATAWIDTH)-1:0], logical
  - MUX2x1: sel?a:b
REQ-017 Stage 2 SHALL compare the expected value to the registered obs, so counters and flags update exactly 2 cycles after acceptance.
REQ-018 The pipeline SHALL sustain one transaction per cycle.
REQ-019 Illegal opcodes, and DIV or MOD with b=0, SHALL increment skip_cnt only.
REQ-020 A match SHALL increment pass_cnt; a mismatch SHALL increment fail_cnt and set err.
REQ-021 On the first mismatch after reset, err_op and err_exp SHALL be captured; later mismatches SHALL not overwrite them.
REQ-022 All counters SHALL saturate at 2^CNTWIDTH-1 and not wrap.
REQ-023 The FSM SHALL have states IDLE, RUN and HALT.
  - IDLE->RUN on the first acceptance.
  - RUN->IDLE when both pipeline stages are empty and chk_valid=0.
  - RUN->HALT only per REQ-029.
  - HALT is left only by rst.
REQ-024 chk_ready SHALL be 1 in IDLE and RUN, and 0 in HALT and during reset.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL set counters=0, err=0, err_op=0, err_exp=0, state=IDLE and chk_ready=0.
REQ-026 A reset SHALL discard all in-flight pipeline stages; no counter update may occur from a transaction accepted before rst.
REQ-027 chk_ready SHALL return to 1 on the first edge after rst falls.

Configuration
REQ-028 Macro CHECKER_STOP_ON_FAIL_EN SHALL select the behaviour after a mismatch.
REQ-029 With CHECKER_STOP_ON_FAIL_EN defined, the first mismatch SHALL move the FSM to HALT in the same cycle that fail_cnt increments. The transaction in stage 1 at that time SHALL still complete and be counted.
REQ-030 Without CHECKER_STOP_ON_FAIL_EN, the HALT state SHALL be unreachable and checking SHALL continue after mismatches.

Verification (DATAWIDTH=4)
REQ-031 The bench SHALL drive ADD a=1 b=2 obs=3, then SHR a=8 b=2 obs=2 on consecutive cycles -> pass_cnt=1 at acceptance+2 and 2 at acceptance+3; err=0.
REQ-032 The bench SHALL drive MUL a=4 b=2 obs=9 -> fail_cnt=1, err=1, err_op=2, err_exp=8.
REQ-033 The bench SHALL then drive SUB a=5 b=4 obs=0 -> fail_cnt=2, with err_op still 2 and err_exp still 8 (without the macro).
REQ-034 The bench SHALL drive DIV a=6 b=0, then op=12 -> skip_cnt=2, pass_cnt and fail_cnt unchanged.
REQ-035 The bench SHALL drive MUX2x1 sel=1 a=2 b=3 obs=2 and assert rst in the cycle after acceptance -> all counters 0, pass_cnt never increments.
REQ-036 With CHECKER_STOP_ON_FAIL_EN, the bench SHALL drive DEC a=4 obs=2, then INC a=5 obs=6 -> fail_cnt=1, pass_cnt=1, chk_ready=0 until rst.
